// File: rtl/multicyc_mem_ctrl_pkg.sv
// Shared types for the multicycle memory controller: FSM states,
// access kinds and the request-priority helper.
package MultcycCtrl;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } memctrl_state_t;

  // KIND_LOAD is encoded as zero so the reset value of the latched kind is a load
  typedef enum logic [1:0] {
    KIND_LOAD  = 2'd0,
    KIND_FETCH = 2'd1,
    KIND_WR    = 2'd2
  } access_kind_t;

  // Stores win over instruction fetches, which win over data loads
  function automatic access_kind_t selectKind(input logic wr, input logic fetch);
    if (wr) begin
      return KIND_WR;
    end else if (fetch) begin
      return KIND_FETCH;
    end
    return KIND_LOAD;
  endfunction

endpackage

// File: rtl/multicyc_mem_ctrl.sv
// Multicycle-CPU memory controller: accepts one fetch/load/store from the
// MCU, runs it on the external bus with an ack timeout, and holds the MCU
// stalled until the result is in the instruction or memory data register.
module multicyc_mem_ctrl
  import MultcycCtrl::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        ir_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_stall,
  output logic [31:0] instr,
  output logic [31:0] mem_data,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  memctrl_state_t state_q, state_d;
  access_kind_t   kind_q, kind_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    instr_q, instr_d;
  logic [31:0]    memData_q, memData_d;
  logic           addrErr_q, addrErr_d;
  logic           busErr_q, busErr_d;
  logic           reqPresent;

  assign reqPresent = mem_wr | ir_we | mem_rd;

  assign instr    = instr_q;
  assign mem_data = memData_q;
  assign addr_err = addrErr_q;
  assign bus_err  = busErr_q;

  // Next-state, register updates and bus/stall outputs for the IDLE/BUS/DONE flow
  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    memData_d = memData_q;
    addrErr_d = addrErr_q;
    busErr_d  = busErr_q;
    mem_stall = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;

    unique case (state_q)
      IDLE: begin
        if (reqPresent) begin
          mem_stall = 1'b1;
          kind_d    = selectKind(mem_wr, ir_we);
          addr_d    = mem_addr;
          wdata_d   = mem_wdata;
          if (mem_addr[1:0] == 2'b00) begin
            cnt_d   = '0;
            state_d = BUS;
          end else begin
            addrErr_d = 1'b1;
            state_d   = DONE;
          end
        end
      end

      BUS: begin
        mem_stall = 1'b1;
        bus_req   = 1'b1;
        bus_we    = (kind_q == KIND_WR);
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        if (bus_ack) begin
          if (kind_q == KIND_FETCH) begin
            instr_d = bus_rdata;
          end else if (kind_q == KIND_LOAD) begin
            memData_d = bus_rdata;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          busErr_d = 1'b1;
          if (kind_q == KIND_FETCH) begin
            instr_d = 32'd0;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All controller state, cleared asynchronously so a reset mid-BUS drops bus_req at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      kind_q    <= KIND_LOAD;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      cnt_q     <= '0;
      instr_q   <= 32'd0;
      memData_q <= 32'd0;
      addrErr_q <= 1'b0;
      busErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      memData_q <= memData_d;
      addrErr_q <= addrErr_d;
      busErr_q  <= busErr_d;
    end
  end

endmodule

// File: tb/tb_multicyc_mem_ctrl.sv
// Self-checking bench for multicyc_mem_ctrl: directed vector table,
// reset-during-bus sequence, and randomized transactions against a
// transaction-level reference model.
module tb_multicyc_mem_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        reset_n;
  logic        mem_rd, mem_wr, ir_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_stall;
  logic [31:0] instr, mem_data;
  logic        addr_err, bus_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int checks = 0;
  int errors = 0;

  // results of the most recent transaction
  int          rStall, rBus;
  logic        rSigOk, rDone, rDoneReq;
  logic [31:0] rInstr, rMd;
  logic        rAe, rBe;

  // reference model state
  logic [31:0] mInstr, mMd;
  logic        mAe, mBe;

  typedef struct {
    logic        wr, we, rd;
    logic [31:0] addr, wdata, rdata;
    int          ackDelay;
    int          expStall, expBus;
    logic [31:0] expInstr, expMd;
    logic        expAe, expBe;
  } vec_t;

  vec_t vecs[8];

  multicyc_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .ir_we     (ir_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_stall (mem_stall),
    .instr     (instr),
    .mem_data  (mem_data),
    .addr_err  (addr_err),
    .bus_err   (bus_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  // 10 ns free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one MCU request, holds it until stall drops (DONE), answers the bus
  // with ack on BUS cycle index ackDelay, then releases the request.
  task automatic applyStimulus(input logic wr, input logic we, input logic rd,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int ackDelay);
    mem_wr = wr; ir_we = we; mem_rd = rd;
    mem_addr = addr; mem_wdata = wdata;
    rStall = 0; rBus = 0; rSigOk = 1'b1; rDone = 1'b0;
    rInstr = 'x; rMd = 'x; rAe = 1'bx; rBe = 1'bx; rDoneReq = 1'bx;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus_ack = 1'b0;
      #1;
      if (bus_req === 1'b1) begin
        if (bus_we !== wr || bus_addr !== addr || bus_wdata !== wdata) rSigOk = 1'b0;
        if (rBus == ackDelay) begin
          bus_ack = 1'b1;
          bus_rdata = rdata;
        end
        rBus++;
      end else begin
        if (bus_we !== 1'b0 || bus_addr !== 32'd0 || bus_wdata !== 32'd0) rSigOk = 1'b0;
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
      if (mem_stall !== 1'b1) begin
        rDone = 1'b1;
        rInstr = instr; rMd = mem_data; rAe = addr_err; rBe = bus_err;
        rDoneReq = bus_req;
        break;
      end
      rStall++;
      @(posedge clk); #1;
    end
    mem_wr = 1'b0; ir_we = 1'b0; mem_rd = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic checkTxn(input string tag, input int expStall, input int expBus,
                          input logic [31:0] expInstr, input logic [31:0] expMd,
                          input logic expAe, input logic expBe);
    checkOutput({tag, " done"}, 32'(rDone), 32'd1);
    checkOutput({tag, " stall cycles"}, rStall, expStall);
    checkOutput({tag, " bus cycles"}, rBus, expBus);
    checkOutput({tag, " bus signals"}, 32'(rSigOk), 32'd1);
    checkOutput({tag, " bus_req in DONE"}, 32'(rDoneReq), 32'd0);
    checkOutput({tag, " instr"}, rInstr, expInstr);
    checkOutput({tag, " mem_data"}, rMd, expMd);
    checkOutput({tag, " addr_err"}, 32'(rAe), 32'(expAe));
    checkOutput({tag, " bus_err"}, 32'(rBe), 32'(expBe));
  endtask

  initial begin
    int expBus;
    logic wr, we, rd;
    logic [31:0] addr, wdata, rdata;
    int dly;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h2008_0005, 0, 2, 1, 32'h2008_0005, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1111_1111, 3, 5, 4, 32'h2008_0005, 32'h0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0, 32'h1234_5678, 1, 3, 2, 32'h2008_0005, 32'h1234_5678, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_0102, 32'h0, 32'h9999_9999, 0, 1, 0, 32'h2008_0005, 32'h1234_5678, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 0, 2, 1, 32'h2008_0005, 32'hCAFE_F00D, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h7777_7777, 99, 5, 4, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'h8C08_0004, 2, 4, 3, 32'h8C08_0004, 32'hCAFE_F00D, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h55AA_55AA, 32'hFFFF_FFFF, 0, 2, 1, 32'h8C08_0004, 32'hCAFE_F00D, 1'b1, 1'b1};

    mem_rd = 1'b0; mem_wr = 1'b0; ir_we = 1'b0;
    mem_addr = 32'd0; mem_wdata = 32'd0;
    bus_rdata = 32'd0; bus_ack = 1'b0;
    reset_n = 1'b0;

    // reset state
    #12;
    checkOutput("reset mem_stall", 32'(mem_stall), 32'd0);
    checkOutput("reset bus_req", 32'(bus_req), 32'd0);
    checkOutput("reset instr", instr, 32'd0);
    checkOutput("reset mem_data", mem_data, 32'd0);
    checkOutput("reset addr_err", 32'(addr_err), 32'd0);
    checkOutput("reset bus_err", 32'(bus_err), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle no-request stall", 32'(mem_stall), 32'd0);

    // directed vector table
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].we, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdata, vecs[i].ackDelay);
      checkTxn($sformatf("vec%0d", i), vecs[i].expStall, vecs[i].expBus,
               vecs[i].expInstr, vecs[i].expMd, vecs[i].expAe, vecs[i].expBe);
    end

    // reset during the second BUS cycle of a load
    mem_rd = 1'b1; mem_addr = 32'h0000_0300; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mid-bus bus_req before reset", 32'(bus_req), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid-bus bus_req after reset", 32'(bus_req), 32'd0);
    checkOutput("mid-bus mem_data after reset", mem_data, 32'd0);
    checkOutput("mid-bus instr after reset", instr, 32'd0);
    checkOutput("mid-bus errors after reset", {30'd0, addr_err, bus_err}, 32'd0);
    mem_rd = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(posedge clk); #1;
    checkOutput("late ack mem_data", mem_data, 32'd0);
    checkOutput("late ack bus_req", 32'(bus_req), 32'd0);
    checkOutput("late ack stall", 32'(mem_stall), 32'd0);

    // randomized transactions against the transaction-level model
    mInstr = 32'd0; mMd = 32'd0; mAe = 1'b0; mBe = 1'b0;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: begin wr = 1'b1; we = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1)); end
        1: begin wr = 1'b0; we = 1'b1; rd = 1'($urandom_range(0, 1)); end
        default: begin wr = 1'b0; we = 1'b0; rd = 1'b1; end
      endcase
      addr  = {$urandom_range(0, 32'h3FFF), 2'b00};
      if ($urandom_range(0, 4) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      wdata = $urandom;
      rdata = $urandom;
      dly   = $urandom_range(0, TO + 1);

      if (addr[1:0] != 2'b00) begin
        mAe = 1'b1;
        expBus = 0;
      end else if (dly < TO) begin
        expBus = dly + 1;
        if (!wr && we) mInstr = rdata;
        else if (!wr && !we) mMd = rdata;
      end else begin
        expBus = TO;
        mBe = 1'b1;
        if (!wr && we) mInstr = 32'd0;
      end

      applyStimulus(wr, we, rd, addr, wdata, rdata, dly);
      checkTxn($sformatf("rand%0d", n), 1 + expBus, expBus, mInstr, mMd, mAe, mBe);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicyc_mem_ctrl.md
MULTICYC_MEM_CTRL -- requirements
Module: multicyc_mem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: the maximum number of BUS cycles to wait for bus_ack.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports mem_rd, mem_wr, ir_we, input, 1 bit each: access requests from the multicycle MCU.
REQ-005 SHALL have port mem_addr, input, 32 bits: byte address, already selected (PC or ALUout).
REQ-006 SHALL have port mem_wdata, input, 32 bits: store data (Rt).
REQ-007 SHALL have port mem_stall, output, 1 bit: MCU holds its state and outputs while this is high.
REQ-008 SHALL have port instr, output, 32 bits: instruction register, feeds opcode/Rs/Rt/Rd/imm decode.
REQ-009 SHALL have port mem_data, output, 32 bits: memory data register, feeds write-back.
REQ-010 SHALL have ports addr_err and bus_err, output, 1 bit each: sticky error flags.
REQ-011 SHALL have ports bus_req and bus_we, output, 1 bit each, plus bus_addr and bus_wdata, output, 32 bits each: external memory request.
REQ-012 SHALL have ports bus_rdata, input, 32 bits, and bus_ack, input, 1 bit: memory response.

Function
REQ-013 SHALL implement states IDLE, BUS, DONE.
REQ-014 In IDLE, a request is present when mem_wr|ir_we|mem_rd; priority mem_wr > ir_we > mem_rd; kind (WR/FETCH/LOAD), mem_addr and mem_wdata latched on accept.
REQ-015 mem_stall SHALL be high combinationally in IDLE when a request is present, high throughout BUS, low in DONE and in idle-without-request.
REQ-016 Aligned accept (mem_addr[1:0]==0): IDLE->BUS; misaligned: addr_err<=1, no bus_req, IDLE->DONE, instr/mem_data unchanged.
REQ-017 In BUS: bus_req=1, bus_we=(kind==WR), bus_addr/bus_wdata from latched registers; all four SHALL be 0 outside BUS.
REQ-018 In BUS with bus_ack=1: FETCH loads instr<=bus_rdata, LOAD loads mem_data<=bus_rdata, WR loads nothing; BUS->DONE.
REQ-019 Timeout counter SHALL clear on entry to BUS and increment each BUS cycle without ack; when it reaches TIMEOUT-1 without ack: bus_err<=1, FETCH loads instr<=0 (NOP), BUS->DONE.
REQ-020 DONE SHALL last exactly one cycle, ignore all request inputs, and always go to IDLE (prevents re-accepting the held request).
REQ-021 Minimum aligned latency: stall high for 2 cycles (accept, BUS+ack), DONE on cycle 3; each cycle of ack delay adds one.
REQ-022 bus_ack outside BUS SHALL be ignored.
REQ-023 addr_err/bus_err SHALL remain set until reset.
REQ-024 Counter width SHALL be $clog2(TIMEOUT+1); TIMEOUT>=1.

Reset
REQ-025 reset_n low SHALL force asynchronously: state IDLE, instr=0, mem_data=0, addr_err=0, bus_err=0, counter=0, latched addr/data/kind=0.
REQ-026 Reset asserted mid-BUS SHALL drop bus_req immediately and abandon the transaction; a later ack is ignored.
REQ-027 First request after reset_n rises SHALL be accepted on the first rising edge at which IDLE sees it.

Structure
REQ-028 State enum memctrl_state_t and access-kind enum SHALL live in package MultcycCtrl; TIMEOUT stays a module parameter.
REQ-029 No sub-module; timeout counter inline; single sequential process plus one combinational next-state/output process.

Verification
REQ-030 ir_we=1, mem_addr=0x0000_0040, ack on first BUS cycle with bus_rdata=0x2008_0005 -> stall high 2 cycles, instr=0x2008_0005 in DONE, mem_data unchanged.
REQ-031 mem_wr=1, addr=0x100, wdata=0xDEAD_BEEF, ack after 3 BUS cycles -> bus_we=1, bus_addr=0x100, bus_wdata=0xDEAD_BEEF held 4 cycles, stall high 5 cycles.
REQ-032 mem_rd=1, addr=0x102 -> addr_err=1, bus_req never asserted, DONE on cycle 2, flag persists across a later good access.
REQ-033 TIMEOUT=4, fetch, ack never -> bus_err=1 after 4 BUS cycles, instr=0, next fetch with ack completes normally.
REQ-034 mem_wr=1 and mem_rd=1 together with ir_we=1 -> write performed, instr and mem_data unchanged; MCU request held through DONE -> no second bus_req.
REQ-035 reset_n low during 2nd BUS cycle of load -> bus_req=0 same cycle, mem_data=0; ack pulse after release ignored.
